osc_tick_gen: RTL and testbench



---
 rtl/osc_tick_gen.sv | 112 +++++++++++
 tb/tb_osc_tick_gen.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/osc_tick_gen.sv
// Multi-channel tick generator clocked by the RC oscillator, with a runtime-programmable divisor per channel.
// Define OSC_TICK_GEN_HEARTBEAT_EN to build the HB toggle flop on channel 0; otherwise HB is tied low.
module osc_tick_gen #(
    parameter int NUM_CH  = 4,
    parameter int DIV_W   = 20,
    parameter int DEF_DIV = 1000,
    localparam int CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              CLK,
    input  logic              RESETN,
    input  logic              EN,
    input  logic              CFG_VALID,
    output logic              CFG_READY,
    input  logic [CH_W-1:0]   CFG_CH,
    input  logic [DIV_W-1:0]  CFG_DIV,
    output logic              CFG_ERR,
    output logic [NUM_CH-1:0] TICK,
    output logic              HB
);

    localparam logic [DIV_W-1:0] DEF_DIV_V = DIV_W'(DEF_DIV);
    localparam logic [DIV_W-1:0] DEF_CNT_V = (DEF_DIV == 0) ? '0 : DIV_W'(DEF_DIV - 1);

    logic [DIV_W-1:0]  div_q [NUM_CH];
    logic [DIV_W-1:0]  cnt_q [NUM_CH];
    logic [DIV_W-1:0]  div_d [NUM_CH];
    logic [DIV_W-1:0]  cnt_d [NUM_CH];
    logic [NUM_CH-1:0] tick_q;
    logic [NUM_CH-1:0] tick_d;
    logic              busy_q;
    logic [CH_W-1:0]   pend_ch_q;
    logic              pend_ok_q;
    logic              err_q;
    logic              accept;
    logic [31:0]       cfg_ch_ext;
    logic              cfg_ch_ok;

    // Channel index is widened before the range test so non-power-of-two NUM_CH is handled.
    assign cfg_ch_ext = 32'(CFG_CH);
    assign cfg_ch_ok  = cfg_ch_ext < 32'(NUM_CH);
    assign accept     = CFG_VALID & ~busy_q;
    assign CFG_READY  = ~busy_q;
    assign CFG_ERR    = err_q;
    assign TICK       = tick_q;

    // A pending reload takes priority over both the run enable and a terminal count on that channel.
    always_comb begin
        for (int i = 0; i < NUM_CH; i++) begin
            div_d[i]  = div_q[i];
            cnt_d[i]  = cnt_q[i];
            tick_d[i] = 1'b0;
            if (accept && cfg_ch_ok && (CFG_CH == CH_W'(i))) begin
                div_d[i] = CFG_DIV;
            end
            if (busy_q && pend_ok_q && (pend_ch_q == CH_W'(i))) begin
                cnt_d[i] = (div_q[i] == '0) ? '0 : div_q[i] - 1'b1;
            end else if (EN) begin
                if (div_q[i] == '0) begin
                    cnt_d[i] = '0;
                end else if (cnt_q[i] == '0) begin
                    cnt_d[i]  = div_q[i] - 1'b1;
                    tick_d[i] = 1'b1;
                end else begin
                    cnt_d[i] = cnt_q[i] - 1'b1;
                end
            end
        end
    end

    always_ff @(posedge CLK or negedge RESETN) begin
        if (!RESETN) begin
            for (int i = 0; i < NUM_CH; i++) begin
                div_q[i] <= DEF_DIV_V;
                cnt_q[i] <= DEF_CNT_V;
            end
            tick_q    <= '0;
            busy_q    <= 1'b0;
            pend_ch_q <= '0;
            pend_ok_q <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                div_q[i] <= div_d[i];
                cnt_q[i] <= cnt_d[i];
            end
            tick_q <= tick_d;
            busy_q <= accept;
            if (accept) begin
                pend_ch_q <= CFG_CH;
                pend_ok_q <= cfg_ch_ok;
            end
            err_q <= accept & ~cfg_ch_ok;
        end
    end

`ifdef OSC_TICK_GEN_HEARTBEAT_EN
    logic hb_q;

    always_ff @(posedge CLK or negedge RESETN) begin
        if (!RESETN) begin
            hb_q <= 1'b0;
        end else if (tick_d[0]) begin
            hb_q <= ~hb_q;
        end
    end

    assign HB = hb_q;
`else
    assign HB = 1'b0;
`endif

endmodule

// File: tb/tb_osc_tick_gen.sv
// Directed self-checking bench for osc_tick_gen: default cadence, divisor writes, edge divisors,
// freeze/resume, out-of-range writes (on a 3-channel instance), async reset and the heartbeat.
module tb_osc_tick_gen;

`ifdef OSC_TICK_GEN_HEARTBEAT_EN
    localparam bit HB_ON = 1'b1;
`else
    localparam bit HB_ON = 1'b0;
`endif

    logic        CLK;
    logic        RESETN;
    logic        EN;
    logic        cfg_valid;
    logic        cfg_ready;
    logic [1:0]  cfg_ch;
    logic [19:0] cfg_div;
    logic        cfg_err;
    logic [3:0]  tick;
    logic        hb;

    logic        e_valid;
    logic        e_ready;
    logic [1:0]  e_ch;
    logic [7:0]  e_div;
    logic        e_err;
    logic [2:0]  e_tick;
    logic        e_hb;

    int errors = 0;
    int checks = 0;
    int edge_no = 0;
    int hits = 0;
    int ehits = 0;

    osc_tick_gen #(.NUM_CH(4), .DIV_W(20), .DEF_DIV(1000)) u_dut (
        .CLK(CLK), .RESETN(RESETN), .EN(EN),
        .CFG_VALID(cfg_valid), .CFG_READY(cfg_ready), .CFG_CH(cfg_ch), .CFG_DIV(cfg_div),
        .CFG_ERR(cfg_err), .TICK(tick), .HB(hb)
    );

    osc_tick_gen #(.NUM_CH(3), .DIV_W(8), .DEF_DIV(10)) u_err (
        .CLK(CLK), .RESETN(RESETN), .EN(EN),
        .CFG_VALID(e_valid), .CFG_READY(e_ready), .CFG_CH(e_ch), .CFG_DIV(e_div),
        .CFG_ERR(e_err), .TICK(e_tick), .HB(e_hb)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Advance one rising edge and sample 1 ns later, tallying any tick activity.
    task automatic tickEdge();
        @(posedge CLK);
        #1;
        edge_no++;
        if (tick != 4'b0000) hits++;
        if (e_tick != 3'b000) ehits++;
    endtask

    task automatic runTo(input int target);
        while (edge_no < target) tickEdge();
    endtask

    // Present one write for exactly one edge (the accept edge) to the chosen instance.
    task automatic applyStimulus(input bit to_err, input int ch, input int dv);
        if (to_err) begin
            e_valid = 1'b1;
            e_ch    = 2'(ch);
            e_div   = 8'(dv);
        end else begin
            cfg_valid = 1'b1;
            cfg_ch    = 2'(ch);
            cfg_div   = 20'(dv);
        end
        tickEdge();
        cfg_valid = 1'b0;
        e_valid   = 1'b0;
        cfg_ch    = 2'd0;
        e_ch      = 2'd0;
    endtask

    task automatic doReset();
        @(negedge CLK);
        RESETN = 1'b0;
        @(negedge CLK);
        RESETN = 1'b1;
        edge_no = 0;
        hits    = 0;
        ehits   = 0;
    endtask

    initial begin
        RESETN    = 1'b1;
        EN        = 1'b1;
        cfg_valid = 1'b0;
        cfg_ch    = 2'd0;
        cfg_div   = 20'd0;
        e_valid   = 1'b0;
        e_ch      = 2'd0;
        e_div     = 8'd0;

        #2 RESETN = 1'b0;
        #1;
        checkOutput("rst_tick", 32'(tick), 32'h0);
        checkOutput("rst_ready", 32'(cfg_ready), 32'h1);
        checkOutput("rst_err", 32'(cfg_err), 32'h0);
        checkOutput("rst_hb", 32'(hb), 32'h0);
        @(negedge CLK);
        RESETN  = 1'b1;
        edge_no = 0;
        hits    = 0;

        // Default cadence: all four channels strobe after edges 1000, 2000, 3000.
        runTo(999);
        checkOutput("quiet_to_999", 32'(hits), 32'h0);
        runTo(1000);
        checkOutput("tick_1000", 32'(tick), 32'hF);
        hits = 0;
        runTo(1999);
        checkOutput("quiet_1001_1999", 32'(hits), 32'h0);
        runTo(2000);
        checkOutput("tick_2000", 32'(tick), 32'hF);
        hits = 0;
        runTo(2999);
        checkOutput("quiet_2001_2999", 32'(hits), 32'h0);
        runTo(3000);
        checkOutput("tick_3000", 32'(tick), 32'hF);
        runTo(3001);
        checkOutput("tick_3001", 32'(tick), 32'h0);
        checkOutput("hb_default", 32'(hb), HB_ON ? 32'h1 : 32'h0);

        // Divisor write: ch2 <- 5 accepted at edge 50.
        doReset();
        runTo(49);
        checkOutput("ready_pre_50", 32'(cfg_ready), 32'h1);
        applyStimulus(1'b0, 2, 5);
        checkOutput("ready_low_51", 32'(cfg_ready), 32'h0);
        checkOutput("err_inrange", 32'(cfg_err), 32'h0);
        hits = 0;
        runTo(51);
        checkOutput("ready_back_52", 32'(cfg_ready), 32'h1);
        runTo(55);
        checkOutput("quiet_51_55", 32'(hits), 32'h0);
        runTo(56);
        checkOutput("tick2_56", 32'(tick), 32'h4);
        hits = 0;
        runTo(60);
        checkOutput("quiet_57_60", 32'(hits), 32'h0);
        runTo(61);
        checkOutput("tick2_61", 32'(tick), 32'h4);
        runTo(66);
        checkOutput("tick2_66", 32'(tick), 32'h4);
        runTo(1000);
        checkOutput("tick_1000_mix", 32'(tick), 32'hB);
        runTo(1001);
        checkOutput("tick2_1001", 32'(tick), 32'h4);

        // Divisor 1 on ch1 accepted at edge 1010, then divisor 0 accepted at edge 1020.
        runTo(1009);
        applyStimulus(1'b0, 1, 1);
        runTo(1011);
        checkOutput("d1_reload_1011", 32'(tick[1]), 32'h0);
        for (int e = 1012; e <= 1016; e++) begin
            runTo(e);
            checkOutput($sformatf("d1_high_%0d", e), 32'(tick[1]), 32'h1);
        end
        runTo(1019);
        applyStimulus(1'b0, 1, 0);
        for (int e = 1021; e <= 1024; e++) begin
            runTo(e);
            checkOutput($sformatf("d0_low_%0d", e), 32'(tick[1]), 32'h0);
        end

        // Freeze: EN low for edges 400..699; next tick lands at edge 1300.
        doReset();
        runTo(399);
        EN = 1'b0;
        runTo(699);
        EN = 1'b1;
        runTo(999);
        checkOutput("frz_quiet_1000", 32'(tick), 32'h0);
        runTo(1299);
        checkOutput("frz_quiet_to_1299", 32'(hits), 32'h0);
        runTo(1300);
        checkOutput("frz_tick_1300", 32'(tick), 32'hF);

        // Async reset mid-count with a write in flight.
        doReset();
        runTo(9);
        applyStimulus(1'b0, 0, 1);
        runTo(698);
        applyStimulus(1'b0, 3, 7);
        checkOutput("pre_rst_tick", 32'(tick), 32'h1);
        #2 RESETN = 1'b0;
        #1;
        checkOutput("mid_rst_tick", 32'(tick), 32'h0);
        checkOutput("mid_rst_ready", 32'(cfg_ready), 32'h1);
        checkOutput("mid_rst_err", 32'(cfg_err), 32'h0);
        @(negedge CLK);
        RESETN  = 1'b1;
        edge_no = 0;
        hits    = 0;
        runTo(999);
        checkOutput("post_rst_quiet", 32'(hits), 32'h0);
        runTo(1000);
        checkOutput("post_rst_tick", 32'(tick), 32'hF);

        // Out-of-range write (ch 3 on a 3-channel instance, DEF_DIV 10).
        doReset();
        runTo(10);
        checkOutput("e_tick_10", 32'(e_tick), 32'h7);
        runTo(14);
        checkOutput("e_err_pre", 32'(e_err), 32'h0);
        applyStimulus(1'b1, 3, 2);
        checkOutput("e_err_pulse", 32'(e_err), 32'h1);
        checkOutput("e_ready_low", 32'(e_ready), 32'h0);
        ehits = 0;
        runTo(16);
        checkOutput("e_err_clear", 32'(e_err), 32'h0);
        checkOutput("e_ready_back", 32'(e_ready), 32'h1);
        runTo(19);
        checkOutput("e_quiet_16_19", 32'(ehits), 32'h0);
        runTo(20);
        checkOutput("e_tick_20", 32'(e_tick), 32'h7);

        // Heartbeat: ch0 <- 4 at edge 10, ticks after 15, 19, 23.
        doReset();
        runTo(9);
        applyStimulus(1'b0, 0, 4);
        runTo(14);
        checkOutput("hb_14", 32'(hb), 32'h0);
        runTo(15);
        checkOutput("hb_tick_15", 32'(tick[0]), 32'h1);
        checkOutput("hb_15", 32'(hb), HB_ON ? 32'h1 : 32'h0);
        runTo(18);
        checkOutput("hb_18", 32'(hb), HB_ON ? 32'h1 : 32'h0);
        runTo(19);
        checkOutput("hb_tick_19", 32'(tick[0]), 32'h1);
        checkOutput("hb_19", 32'(hb), 32'h0);
        runTo(23);
        checkOutput("hb_23", 32'(hb), HB_ON ? 32'h1 : 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
